// File: rtl/hist_pkg.sv
// Shared constants, state encoding and the saturating increment used by the
// histogram scan controller and its read-modify-write pipe.
package hist_pkg;

    localparam int NPIX   = 4096;
    localparam int ADDR_W = 12;
    localparam int PIX_W  = 6;
    localparam int NBINS  = 1 << PIX_W;
    localparam int CNT_W  = 13;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [PIX_W-1:0]  LAST_BIN = PIX_W'(NBINS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        RD_ISSUE,
        RD_PRESENT,
        DONE
    } state_t;

    // Counts stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hist_scan_ctrl_if.sv
// Bundles the control handshake, pixel mux, count-BRAM ports and histogram
// readout stream of the scan controller.
//   master : controller side (drives busy/done, pix_addr, BRAM address/write, readout)
//   slave  : environment side (drives start, pix_in, BRAM read data, hist_ready)
interface hist_scan_ctrl_if;
    import hist_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pix_addr;
    logic [PIX_W-1:0]  pix_in;
    logic [PIX_W-1:0]  bin_rd_addr;
    logic [CNT_W-1:0]  bin_rd_data;
    logic              bin_wr_en;
    logic [PIX_W-1:0]  bin_wr_addr;
    logic [CNT_W-1:0]  bin_wr_data;
    logic              hist_valid;
    logic              hist_ready;
    logic [PIX_W-1:0]  hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              hist_last;

    modport master (
        input  start, pix_in, bin_rd_data, hist_ready,
        output busy, done, pix_addr, bin_rd_addr, bin_wr_en, bin_wr_addr,
               bin_wr_data, hist_valid, hist_bin, hist_count, hist_last
    );

    modport slave (
        output start, pix_in, bin_rd_data, hist_ready,
        input  busy, done, pix_addr, bin_rd_addr, bin_wr_en, bin_wr_addr,
               bin_wr_data, hist_valid, hist_bin, hist_count, hist_last
    );

endinterface

// File: rtl/hist_rmw_pipe.sv
// Two-stage read-modify-write pipe for the bin counters, plus the BRAM port mux.
//   clk, rst        clock, synchronous active-high reset
//   clear_en/addr   CLEAR phase: write zero to clear_addr
//   scan_en/pix_in  SCAN phase: capture a pixel into S0 this cycle
//   rd_en/rd_addr   readout phase: read address override
//   bin_rd_data     BRAM read data (1-cycle latency, read-first)
//   bin_rd_addr, bin_wr_en, bin_wr_addr, bin_wr_data   BRAM port drive
module hist_rmw_pipe
    import hist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_en,
    input  logic [PIX_W-1:0] clear_addr,
    input  logic             scan_en,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             rd_en,
    input  logic [PIX_W-1:0] rd_addr,
    input  logic [CNT_W-1:0] bin_rd_data,
    output logic [PIX_W-1:0] bin_rd_addr,
    output logic             bin_wr_en,
    output logic [PIX_W-1:0] bin_wr_addr,
    output logic [CNT_W-1:0] bin_wr_data
);

    logic             s0_valid_q, s0_valid_d;
    logic [PIX_W-1:0] s0_pix_q, s0_pix_d;
    logic             s1_valid_q, s1_valid_d;
    logic [PIX_W-1:0] s1_pix_q, s1_pix_d;
    logic             fwd_q, fwd_d;
    logic [CNT_W-1:0] last_wr_q, last_wr_d;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] inc;

    always_comb begin
        s0_valid_d = scan_en;
        s0_pix_d   = scan_en ? pix_in : '0;
        s1_valid_d = s0_valid_q;
        s1_pix_d   = s0_pix_q;
        // The BRAM read issued for S0 coincides with S1's write; when both hit
        // the same bin the read returns the pre-write value, so take the value
        // S1 is writing instead, one cycle later.
        fwd_d      = s0_valid_q && s1_valid_q && (s0_pix_q == s1_pix_q);
        base       = fwd_q ? last_wr_q : bin_rd_data;
        inc        = sat_inc(base);
        last_wr_d  = s1_valid_q ? inc : last_wr_q;
    end

    always_comb begin
        bin_wr_en   = clear_en | s1_valid_q;
        bin_wr_addr = '0;
        bin_wr_data = '0;
        if (clear_en) begin
            bin_wr_addr = clear_addr;
        end else if (s1_valid_q) begin
            bin_wr_addr = s1_pix_q;
            bin_wr_data = inc;
        end
        bin_rd_addr = rd_en ? rd_addr : s0_pix_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_pix_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            fwd_q      <= 1'b0;
            last_wr_q  <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_pix_q   <= s0_pix_d;
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            fwd_q      <= fwd_d;
            last_wr_q  <= last_wr_d;
        end
    end

endmodule

// File: rtl/hist_scan_ctrl.sv
// Sequences one histogram pass: clear the 64 bins, scan every pixel through
// the RMW pipe, drain it, then stream the bins out over valid/ready.
//   clk  system clock
//   rst  synchronous active-high reset; aborts a pass immediately
//   bus  hist_scan_ctrl_if.master: start/busy/done, pixel mux, BRAM, readout
//
// state      | meaning
// IDLE       | waiting for start
// CLEAR      | write zero to bin idx (64 cycles)
// SCAN       | present pix_addr 0..NPIX-1, one per cycle
// DRAIN      | two cycles letting S0/S1 retire the last pixels
// RD_ISSUE   | read address = bin idx
// RD_PRESENT | beat valid with the read data; advance on ready
// DONE       | one-cycle done pulse
module hist_scan_ctrl
    import hist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    hist_scan_ctrl_if.master  bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [PIX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hist_valid_q, hist_valid_d;
    logic [PIX_W-1:0]  hist_bin_q, hist_bin_d;
    logic              hist_last_q, hist_last_d;

    always_comb begin
        state_d      = state_q;
        pix_addr_d   = pix_addr_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        hist_valid_d = hist_valid_q;
        hist_bin_d   = hist_bin_q;
        hist_last_d  = hist_last_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_BIN) begin
                    state_d    = SCAN;
                    idx_d      = '0;
                    pix_addr_d = '0;
                end
            end
            SCAN: begin
                pix_addr_d = pix_addr_q + 1'b1;
                if (pix_addr_q == LAST_PIX) begin
                    state_d    = DRAIN;
                    pix_addr_d = '0;
                    idx_d      = '0;
                end
            end
            DRAIN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == PIX_W'(1)) begin
                    state_d = RD_ISSUE;
                    idx_d   = '0;
                end
            end
            RD_ISSUE: begin
                state_d      = RD_PRESENT;
                hist_valid_d = 1'b1;
                hist_bin_d   = idx_q;
                hist_last_d  = (idx_q == LAST_BIN);
            end
            RD_PRESENT: begin
                if (bus.hist_ready) begin
                    hist_valid_d = 1'b0;
                    hist_last_d  = 1'b0;
                    if (idx_q == LAST_BIN) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        state_d = RD_ISSUE;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pix_addr_q   <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= '0;
            hist_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_addr_q   <= pix_addr_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            hist_last_q  <= hist_last_d;
        end
    end

    // The read address is held through RD_PRESENT, so the BRAM output register
    // keeps presenting the same count while the beat is stalled.
    hist_rmw_pipe u_rmw (
        .clk         (clk),
        .rst         (rst),
        .clear_en    (state_q == CLEAR),
        .clear_addr  (idx_q),
        .scan_en     (state_q == SCAN),
        .pix_in      (bus.pix_in),
        .rd_en       ((state_q == RD_ISSUE) || (state_q == RD_PRESENT)),
        .rd_addr     (idx_q),
        .bin_rd_data (bus.bin_rd_data),
        .bin_rd_addr (bus.bin_rd_addr),
        .bin_wr_en   (bus.bin_wr_en),
        .bin_wr_addr (bus.bin_wr_addr),
        .bin_wr_data (bus.bin_wr_data)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pix_addr   = pix_addr_q;
    assign bus.hist_valid = hist_valid_q;
    assign bus.hist_bin   = hist_bin_q;
    assign bus.hist_last  = hist_last_q;
    assign bus.hist_count = hist_valid_q ? bus.bin_rd_data : '0;

endmodule

// File: tb/tb_hist_scan_ctrl.sv
module tb_hist_scan_ctrl;
    import hist_pkg::*;

    logic clk;
    logic rst;
    hist_scan_ctrl_if bus();

    hist_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count BRAM model: 1-cycle read latency, read-first.
    logic [CNT_W-1:0] mem [NBINS];
    always @(posedge clk) begin
        bus.bin_rd_data <= mem[bus.bin_rd_addr];
        if (bus.bin_wr_en) mem[bus.bin_wr_addr] <= bus.bin_wr_data;
    end

    // Pixel mux model: 0 = addr[5:0], 1 = constant 5, 2 = 3,3,7,3 repeating.
    int mode;
    always_comb begin
        case (mode)
            0:       bus.pix_in = bus.pix_addr[5:0];
            1:       bus.pix_in = 6'd5;
            default: bus.pix_in = (bus.pix_addr[1:0] == 2'd2) ? 6'd7 : 6'd3;
        endcase
    end

    int n_assert;
    int n_fail;
    logic [31:0] got [NBINS];
    logic [31:0] expv [NBINS];
    int beats, order_err, last_bad, done_cnt, done_cyc, wr_bad, hold_bad;
    int busy_gap, busy_after;
    logic [31:0] held_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_expect(input int m);
        for (int b = 0; b < NBINS; b++) begin
            case (m)
                0:       expv[b] = 64;
                1:       expv[b] = (b == 5) ? 4096 : 0;
                default: expv[b] = (b == 3) ? 3072 : ((b == 7) ? 1024 : 0);
            endcase
        end
    endtask

    task automatic run_pass(input int stall_bin, input bit poke);
        int cyc;
        int exp_bin;
        bit stalled;
        logic [PIX_W-1:0] hb;
        beats = 0; order_err = 0; last_bad = 0; done_cnt = 0; done_cyc = 0;
        wr_bad = 0; hold_bad = 0; busy_gap = 0; busy_after = 0; held_count = 0;
        for (int b = 0; b < NBINS; b++) got[b] = 32'hffff_ffff;
        bus.hist_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; exp_bin = 0; stalled = 1'b0;
        while (done_cnt == 0 && cyc < 6000) begin
            if (poke) bus.start = (cyc == 200) || (bus.hist_valid && bus.hist_bin == 6'd20);
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (!bus.busy) busy_gap++;
            if (bus.bin_wr_en && (beats > 0 || bus.hist_valid)) wr_bad++;
            if (bus.hist_valid && int'(bus.hist_bin) == stall_bin && !stalled) begin
                stalled = 1'b1;
                hb = bus.hist_bin;
                held_count = 32'(bus.hist_count);
                bus.hist_ready = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1; cyc++;
                    if (!(bus.hist_valid && bus.hist_bin == hb && 32'(bus.hist_count) == held_count))
                        hold_bad++;
                end
                bus.hist_ready = 1'b1;
            end
            if (bus.hist_valid && bus.hist_ready) begin
                if (int'(bus.hist_bin) != exp_bin) order_err++;
                got[bus.hist_bin] = 32'(bus.hist_count);
                if (bus.hist_last != (bus.hist_bin == LAST_BIN)) last_bad++;
                beats++; exp_bin++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.start = 1'b0;
        repeat (50) begin
            if (bus.done) done_cnt++;
            if (bus.busy) busy_after++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_pass(input string name);
        check({name, "_beats"}, 32'(beats), 64);
        check({name, "_order"}, 32'(order_err), 0);
        check({name, "_last"}, 32'(last_bad), 0);
        check({name, "_done_pulses"}, 32'(done_cnt), 1);
        check({name, "_wr_in_readout"}, 32'(wr_bad), 0);
        check({name, "_busy_gap"}, 32'(busy_gap), 0);
        check({name, "_busy_after"}, 32'(busy_after), 0);
        for (int b = 0; b < NBINS; b++)
            check($sformatf("%s_bin%0d", name, b), got[b], expv[b]);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        mode = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.hist_ready = 1'b1;
        for (int i = 0; i < NBINS; i++) mem[i] = CNT_W'(i * 97 + 5);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_pix_addr", 32'(bus.pix_addr), 0);
        check("rst_wr_en", 32'(bus.bin_wr_en), 0);
        check("rst_hist_valid", 32'(bus.hist_valid), 0);
        check("rst_hist_last", 32'(bus.hist_last), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: identity pattern, every bin 64, minimum latency
        mode = 0; set_expect(0);
        run_pass(-1, 1'b0);
        check_pass("t1");
        check("t1_latency", 32'(done_cyc), 4291);

        // 2: constant pixel, back-to-back hazard
        mode = 1; set_expect(1);
        run_pass(-1, 1'b0);
        check_pass("t2");

        // 3: 3,3,7,3 forwarding plus non-adjacent RMW
        mode = 2; set_expect(2);
        run_pass(-1, 1'b0);
        check_pass("t3");

        // 4: backpressure at bin 10
        mode = 0; set_expect(0);
        run_pass(10, 1'b0);
        check_pass("t4");
        check("t4_hold", 32'(hold_bad), 0);
        check("t4_held_count", held_count, 64);

        // 5: reset mid-scan, then a clean pass over stale counts
        mode = 0;
        bus.hist_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.pix_addr == ADDR_W'(1000)) break;
            @(posedge clk); #1;
        end
        check("t5_reached_1000", 32'(bus.pix_addr), 1000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        check("t5_pix_addr", 32'(bus.pix_addr), 0);
        check("t5_rd_addr", 32'(bus.bin_rd_addr), 0);
        check("t5_wr_en", 32'(bus.bin_wr_en), 0);
        check("t5_wr_addr", 32'(bus.bin_wr_addr), 0);
        check("t5_wr_data", 32'(bus.bin_wr_data), 0);
        check("t5_hist_valid", 32'(bus.hist_valid), 0);
        check("t5_hist_bin", 32'(bus.hist_bin), 0);
        check("t5_hist_count", 32'(bus.hist_count), 0);
        check("t5_hist_last", 32'(bus.hist_last), 0);
        wr_bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.bin_wr_en || bus.busy) wr_bad++;
        end
        check("t5_idle_quiet", 32'(wr_bad), 0);
        mode = 2; set_expect(2);
        run_pass(-1, 1'b0);
        check_pass("t5");

        // 6: start pulses during SCAN and RD_PRESENT are ignored
        mode = 1; set_expect(1);
        run_pass(-1, 1'b1);
        check_pass("t6");
        check("t6_latency", 32'(done_cyc), 4291);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
